// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit MIPS ALU: stores decoded operands and control,
// decodes ALUctl ahead of the register, and resolves EX/MEM and MEM/WB forwarding on the way out.
module id_ex_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Stall,
  input  logic                Flush,
  input  logic                InValid,
  input  logic [1:0]          ALUOp,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          Funct,
  input  logic [WIDTH-1:0]    RsData,
  input  logic [WIDTH-1:0]    RtData,
  input  logic [WIDTH-1:0]    SignImm,
  input  logic                ALUSrc,
  input  logic [REG_BITS-1:0] Rs,
  input  logic [REG_BITS-1:0] Rt,
  input  logic [REG_BITS-1:0] Rd,
  input  logic                RegDst,
  input  logic                RegWrite,
  input  logic                ExMemRegWrite,
  input  logic [REG_BITS-1:0] ExMemRd,
  input  logic [WIDTH-1:0]    ExMemResult,
  input  logic                MemWbRegWrite,
  input  logic [REG_BITS-1:0] MemWbRd,
  input  logic [WIDTH-1:0]    MemWbResult,
  output logic [WIDTH-1:0]    A,
  output logic [WIDTH-1:0]    B,
  output logic [3:0]          ALUctl,
  output logic                OutValid,
  output logic [REG_BITS-1:0] WriteReg,
  output logic                OutRegWrite
);

  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_NOR = 4'd12;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOP = 4'd15;

  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                regdst;
    logic                alusrc;
    logic [3:0]          aluctl;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [REG_BITS-1:0] rd;
    logic [WIDTH-1:0]    rsdata;
    logic [WIDTH-1:0]    rtdata;
    logic [WIDTH-1:0]    signimm;
  } id_ex_t;

  id_ex_t     q;
  id_ex_t     d;
  logic [3:0] aluctl_dec;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    aluctl_dec = CTL_NOP;
    unique case (ALUOp)
      2'b00: aluctl_dec = CTL_ADD;
      2'b01: aluctl_dec = CTL_SUB;
      2'b10: begin
        case (Funct)
          6'h20:   aluctl_dec = CTL_ADD;
          6'h22:   aluctl_dec = CTL_SUB;
          6'h24:   aluctl_dec = CTL_AND;
          6'h25:   aluctl_dec = CTL_OR;
          6'h27:   aluctl_dec = CTL_NOR;
          6'h2A:   aluctl_dec = CTL_SLT;
          default: aluctl_dec = CTL_NOP;
        endcase
      end
      2'b11: begin
        case (Opcode)
          6'h08:   aluctl_dec = CTL_ADD;
          6'h0C:   aluctl_dec = CTL_AND;
          6'h0D:   aluctl_dec = CTL_OR;
          6'h0A:   aluctl_dec = CTL_SLT;
          default: aluctl_dec = CTL_NOP;
        endcase
      end
      default: aluctl_dec = CTL_NOP;
    endcase
  end

  always_comb begin
    d          = '0;
    d.valid    = InValid;
    d.regwrite = RegWrite & InValid;
    d.regdst   = RegDst;
    d.alusrc   = ALUSrc;
    d.aluctl   = aluctl_dec;
    d.rs       = Rs;
    d.rt       = Rt;
    d.rd       = Rd;
    d.rsdata   = RsData;
    d.rtdata   = RtData;
    d.signimm  = SignImm;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || Flush) begin
      q        <= '0;
      q.aluctl <= CTL_NOP;
    end else if (!Stall) begin
      q <= d;
    end
  end

  // Younger EX/MEM result beats MEM/WB; register 0 is hard-wired and never forwarded.
  function automatic logic [WIDTH-1:0] forward(
    input logic [REG_BITS-1:0] src,
    input logic [WIDTH-1:0]    stored,
    input logic                exmem_we,
    input logic [REG_BITS-1:0] exmem_rd,
    input logic [WIDTH-1:0]    exmem_res,
    input logic                memwb_we,
    input logic [REG_BITS-1:0] memwb_rd,
    input logic [WIDTH-1:0]    memwb_res
  );
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == src))
      return exmem_res;
    else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src))
      return memwb_res;
    else
      return stored;
  endfunction

  logic [WIDTH-1:0] rt_fwd;

  always_comb begin
    A      = forward(q.rs, q.rsdata, ExMemRegWrite, ExMemRd, ExMemResult,
                     MemWbRegWrite, MemWbRd, MemWbResult);
    rt_fwd = forward(q.rt, q.rtdata, ExMemRegWrite, ExMemRd, ExMemResult,
                     MemWbRegWrite, MemWbRd, MemWbResult);
    B      = q.alusrc ? q.signimm : rt_fwd;
  end

  assign ALUctl      = q.aluctl;
  assign OutValid    = q.valid;
  assign OutRegWrite = q.regwrite;
  assign WriteReg    = q.regdst ? q.rd : q.rt;

endmodule
